// File: rtl/chess_clock_ctrl.sv
// Chess clock controller: two BCD mm:ss down-counters driven by a 1 Hz tick,
// with edge-detected start/pause/clear and per-player move buttons.
// Optional feature macro: CHESS_INCREMENT_EN (adds INC_SEC to the moving
// player's time on a move out of RUN_A/RUN_B, saturating at 99:59).
module chess_clock_ctrl #(
    parameter int unsigned INIT_MIN = 5,
    parameter int unsigned INC_SEC  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        k,
    input  logic        left,
    input  logic        right,
    output logic [15:0] time_a,
    output logic [15:0] time_b,
    output logic        run_a,
    output logic        run_b,
    output logic        flag_a,
    output logic        flag_b,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN_A  = 3'd1,
        RUN_B  = 3'd2,
        PAUSED = 3'd3,
        FLAG   = 3'd4
    } state_t;

    localparam logic [15:0] INIT_TIME = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10), 8'h00};

    state_t      cur_state;
    state_t      nxt_state;
    logic        k_sample, k_prev;
    logic        l_sample, l_prev;
    logic        r_sample, r_prev;
    logic        k_ev, l_ev, r_ev;
    logic        saved_b, nxt_saved_b;
    logic [15:0] nxt_a, nxt_b;
    logic [15:0] dec_a, dec_b;
    logic        nxt_flag_a, nxt_flag_b;

    // One-second BCD decrement with borrow through all four digits
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    // Add INC_SEC seconds with carry into minutes, saturating at 99:59
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        int unsigned secs, mins;
        secs = 32'(t[7:4]) * 10 + 32'(t[3:0]) + INC_SEC;
        mins = 32'(t[15:12]) * 10 + 32'(t[11:8]);
        if (secs >= 60) begin
            secs = secs - 60;
            mins = mins + 1;
        end
        if (mins > 99) begin
            return 16'h9959;
        end
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
    endfunction

    assign k_ev  = k_prev & ~k_sample;
    assign l_ev  = l_prev & ~l_sample;
    assign r_ev  = r_prev & ~r_sample;
    assign dec_a = bcd_dec(time_a);
    assign dec_b = bcd_dec(time_b);
    assign state = cur_state;

    // Button history: sample then previous, released (high) after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            k_sample <= 1'b1;
            k_prev   <= 1'b1;
            l_sample <= 1'b1;
            l_prev   <= 1'b1;
            r_sample <= 1'b1;
            r_prev   <= 1'b1;
        end else begin
            k_sample <= k;
            k_prev   <= k_sample;
            l_sample <= left;
            l_prev   <= l_sample;
            r_sample <= right;
            r_prev   <= r_sample;
        end
    end

    // Next-state and next-time decision; expiry outranks k, k outranks moves
    always_comb begin
        nxt_state   = cur_state;
        nxt_a       = time_a;
        nxt_b       = time_b;
        nxt_saved_b = saved_b;
        nxt_flag_a  = flag_a;
        nxt_flag_b  = flag_b;
        case (cur_state)
            IDLE: begin
                if (l_ev && !r_ev) begin
                    nxt_state = RUN_B;
                end else if (r_ev && !l_ev) begin
                    nxt_state = RUN_A;
                end
            end
            RUN_A: begin
                if (tick) begin
                    nxt_a = dec_a;
                end
                if (tick && dec_a == '0) begin
                    nxt_state  = FLAG;
                    nxt_flag_a = 1'b1;
                end else if (k_ev) begin
                    nxt_state   = PAUSED;
                    nxt_saved_b = 1'b0;
                end else if (l_ev) begin
                    nxt_state = RUN_B;
`ifdef CHESS_INCREMENT_EN
                    nxt_a = bcd_inc(nxt_a);
`endif
                end
            end
            RUN_B: begin
                if (tick) begin
                    nxt_b = dec_b;
                end
                if (tick && dec_b == '0) begin
                    nxt_state  = FLAG;
                    nxt_flag_b = 1'b1;
                end else if (k_ev) begin
                    nxt_state   = PAUSED;
                    nxt_saved_b = 1'b1;
                end else if (r_ev) begin
                    nxt_state = RUN_A;
`ifdef CHESS_INCREMENT_EN
                    nxt_b = bcd_inc(nxt_b);
`endif
                end
            end
            PAUSED: begin
                if (k_ev) begin
                    nxt_state = saved_b ? RUN_B : RUN_A;
                end
            end
            FLAG: begin
                if (k_ev) begin
                    nxt_state  = IDLE;
                    nxt_a      = INIT_TIME;
                    nxt_b      = INIT_TIME;
                    nxt_flag_a = 1'b0;
                    nxt_flag_b = 1'b0;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // FSM state, times and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
            time_a    <= INIT_TIME;
            time_b    <= INIT_TIME;
            saved_b   <= 1'b0;
            run_a     <= 1'b0;
            run_b     <= 1'b0;
            flag_a    <= 1'b0;
            flag_b    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            time_a    <= nxt_a;
            time_b    <= nxt_b;
            saved_b   <= nxt_saved_b;
            run_a     <= (nxt_state == RUN_A);
            run_b     <= (nxt_state == RUN_B);
            flag_a    <= nxt_flag_a;
            flag_b    <= nxt_flag_b;
        end
    end

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Self-checking bench for chess_clock_ctrl: seconds-based reference model,
// directed scenarios with literal expectations, then randomized play.
// Honours CHESS_INCREMENT_EN in the model and literal expectations.
module tb_chess_clock_ctrl;

    localparam int INIT_MIN = 5;
    localparam int INC_SEC  = 3;
    localparam int INIT_S   = INIT_MIN * 60;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        k = 1'b1;
    logic        left = 1'b1;
    logic        right = 1'b1;
    logic [15:0] time_a, time_b;
    logic        run_a, run_b, flag_a, flag_b;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    bit model_ok = 1'b0;

    chess_clock_ctrl #(.INIT_MIN(INIT_MIN), .INC_SEC(INC_SEC)) dut (
        .clk(clk), .reset(reset), .tick(tick), .k(k), .left(left), .right(right),
        .time_a(time_a), .time_b(time_b), .run_a(run_a), .run_b(run_b),
        .flag_a(flag_a), .flag_b(flag_b), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: times kept as plain seconds remaining
    int m_state, m_ta, m_tb, m_saved, m_fa, m_fb;
    int n_state, n_ta, n_tb, n_saved, n_fa, n_fb, rem;
    logic m_klast, m_llast, m_rlast, m_kev, m_lev, m_rev;

    function automatic int add_inc(input int s);
`ifdef CHESS_INCREMENT_EN
        return (s + INC_SEC > 5999) ? 5999 : s + INC_SEC;
`else
        return s;
`endif
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m, x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    always_comb begin
        n_state = m_state; n_ta = m_ta; n_tb = m_tb;
        n_saved = m_saved; n_fa = m_fa; n_fb = m_fb;
        rem = 0;
        if (reset) begin
            n_state = 0; n_ta = INIT_S; n_tb = INIT_S;
            n_saved = 0; n_fa = 0; n_fb = 0;
        end else begin
            case (m_state)
                0: begin
                    if (m_lev && !m_rev) n_state = 2;
                    else if (m_rev && !m_lev) n_state = 1;
                end
                1: begin
                    rem = m_ta - (tick ? 1 : 0);
                    if (tick && rem == 0) begin
                        n_state = 4; n_ta = 0; n_fa = 1;
                    end else begin
                        n_ta = rem;
                        if (m_kev) begin n_state = 3; n_saved = 0; end
                        else if (m_lev) begin n_state = 2; n_ta = add_inc(rem); end
                    end
                end
                2: begin
                    rem = m_tb - (tick ? 1 : 0);
                    if (tick && rem == 0) begin
                        n_state = 4; n_tb = 0; n_fb = 1;
                    end else begin
                        n_tb = rem;
                        if (m_kev) begin n_state = 3; n_saved = 1; end
                        else if (m_rev) begin n_state = 1; n_tb = add_inc(rem); end
                    end
                end
                3: begin
                    if (m_kev) n_state = (m_saved == 1) ? 2 : 1;
                end
                default: begin
                    if (m_kev) begin
                        n_state = 0; n_ta = INIT_S; n_tb = INIT_S; n_fa = 0; n_fb = 0;
                    end
                end
            endcase
        end
    end

    // A press becomes an event one edge after the low level is first seen
    always @(posedge clk) begin
        m_state <= n_state; m_ta <= n_ta; m_tb <= n_tb;
        m_saved <= n_saved; m_fa <= n_fa; m_fb <= n_fb;
        m_klast <= reset ? 1'b1 : k;
        m_llast <= reset ? 1'b1 : left;
        m_rlast <= reset ? 1'b1 : right;
        m_kev   <= reset ? 1'b0 : (m_klast & ~k);
        m_lev   <= reset ? 1'b0 : (m_llast & ~left);
        m_rev   <= reset ? 1'b0 : (m_rlast & ~right);
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_ok) begin
            check("m_state", 16'(state), 16'(m_state));
            check("m_time_a", time_a, to_bcd(m_ta));
            check("m_time_b", time_b, to_bcd(m_tb));
            check("m_status", {12'd0, run_a, run_b, flag_a, flag_b},
                  {12'd0, m_state == 1, m_state == 2, m_fa[0], m_fb[0]});
        end
    end

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: k = v;
            1: left = v;
            default: right = v;
        endcase
    endtask

    // Hold low across two edges (event fires on the second), then release
    task automatic press(input int which, input bit with_tick);
        set_btn(which, 1'b0);
        @(negedge clk);
        tick = with_tick;
        @(negedge clk);
        tick = 1'b0;
        set_btn(which, 1'b1);
    endtask

    int changes;
    logic [2:0] last_st;

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_ok = 1'b1;
        check("rst_state", 16'(state), 16'd0);
        check("rst_time_a", time_a, 16'h0500);
        check("rst_time_b", time_b, 16'h0500);
        check("rst_status", {12'd0, run_a, run_b, flag_a, flag_b}, 16'd0);

        // Scenario 1
        press(2, 1'b0);
        ticks(3);
        check("s1_state", 16'(state), 16'd1);
        check("s1_time_a", time_a, 16'h0457);
        check("s1_time_b", time_b, 16'h0500);
        check("s1_run_a", {15'd0, run_a}, 16'd1);

        // Scenario 2
        ticks(237);
        check("s2_time_a_pre", time_a, 16'h0100);
        ticks(1);
        check("s2_time_a_tick", time_a, 16'h0059);
        press(1, 1'b0);
        check("s2_state", 16'(state), 16'd2);
`ifdef CHESS_INCREMENT_EN
        check("s2_time_a", time_a, 16'h0102);
`else
        check("s2_time_a", time_a, 16'h0059);
`endif

        // Scenario 3
        ticks(299);
        check("s3_time_b_pre", time_b, 16'h0001);
        press(2, 1'b1);
        check("s3_state", 16'(state), 16'd4);
        check("s3_status", {12'd0, run_a, run_b, flag_a, flag_b}, 16'b0001);
        check("s3_time_b", time_b, 16'h0000);

        // Scenario 5
        press(0, 1'b0);
        check("s5_state", 16'(state), 16'd0);
        check("s5_times", time_a ^ time_b, 16'h0000);
        check("s5_time_a", time_a, 16'h0500);
        check("s5_flags", {14'd0, flag_a, flag_b}, 16'd0);
        left = 1'b0;
        changes = 0;
        last_st = state;
        repeat (100) begin
            @(negedge clk);
            if (state != last_st) changes++;
            last_st = state;
        end
        left = 1'b1;
        check("s5_hold_changes", 16'(changes), 16'd1);
        check("s5_hold_state", 16'(state), 16'd2);

        // Scenario 4
        ticks(2);
        press(2, 1'b0);
        check("s4_run_state", 16'(state), 16'd1);
        press(0, 1'b0);
        check("s4_pause_state", 16'(state), 16'd3);
        ticks(5);
        press(1, 1'b0);
        press(2, 1'b0);
        check("s4_time_a", time_a, 16'h0500);
`ifdef CHESS_INCREMENT_EN
        check("s4_time_b", time_b, 16'h0501);
`else
        check("s4_time_b", time_b, 16'h0458);
`endif
        check("s4_still_paused", 16'(state), 16'd3);
        press(0, 1'b0);
        check("s4_resume_state", 16'(state), 16'd1);

        // Scenario 6
        ticks(108);
        check("s6_time_a_pre", time_a, 16'h0312);
        left = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        left = 1'b1;
        check("s6_state", 16'(state), 16'd0);
        check("s6_time_a", time_a, 16'h0500);
        repeat (3) @(negedge clk);
        check("s6_no_move", 16'(state), 16'd0);

        // Randomized play
        for (int i = 0; i < 8000; i++) begin
            tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) left = ~left;
            if ($urandom_range(0, 7) == 0) right = ~right;
            if ($urandom_range(0, 15) == 0) k = ~k;
            reset = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        tick = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chess_clock_ctrl.md
CHESS_CLOCK_CTRL -- requirements
Module: chess_clock_ctrl

Interface
REQ-001 Parameter INIT_MIN, default 5, start time per player in minutes; legal range 1..99.
REQ-002 Parameter INC_SEC, default 3, per-move increment in seconds; legal range 0..59; used only under CHESS_INCREMENT_EN.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 tick  in  1  one-clk strobe at 1 Hz, from the existing prescaler.
REQ-006 k  in  1  start/pause/clear button, active-low, already debounced.
REQ-007 left  in  1  player A move button, active-low, already debounced.
REQ-008 right  in  1  player B move button, active-low, already debounced.
REQ-009 time_a  out  16  player A time as BCD {min_tens, min_units, sec_tens, sec_units}.
REQ-010 time_b  out  16  player B time, same format.
REQ-011 run_a / run_b  out  1 each  the player's clock is counting.
REQ-012 flag_a / flag_b  out  1 each  the player's time has expired.
REQ-013 state  out  3  FSM encoding: IDLE=0, RUN_A=1, RUN_B=2, PAUSED=3, FLAG=4.

Function
REQ-014 Each button SHALL be registered twice (sample, previous); press event = previous high AND sample low. The event SHALL act on the same edge it is computed, so the FSM changes at the 2nd rising clk edge after the input is first sampled low.
REQ-015 Holding a button SHALL produce exactly one event; release SHALL produce none.
REQ-016 Event priority within one cycle SHALL be: k first, then left/right. In IDLE, left and right pressed together SHALL be ignored.
REQ-017 IDLE transitions: left -> RUN_B; right -> RUN_A; k ignored; tick ignored.
REQ-018 RUN_A transitions: left -> RUN_B; right ignored; k -> PAUSED, saved player = A.
REQ-019 RUN_B transitions: right -> RUN_A; left ignored; k -> PAUSED, saved player = B.
REQ-020 PAUSED transitions: k -> saved player's RUN state; left, right and tick ignored.
REQ-021 FLAG transitions: k -> IDLE, reloading both times to INIT_MIN:00 and clearing both flags; left and right ignored.
REQ-022 On tick in RUN_A, time_a SHALL decrement by one second in BCD:
  - sec_units 0 -> 9, borrowing from sec_tens;
  - sec_tens 0 -> 5, borrowing from minutes;
  - min_units 0 -> 9, borrowing from min_tens.
  RUN_B SHALL do the same for time_b.
REQ-023 A decrement reaching 00:00 SHALL move to FLAG on the same edge and set flag_a or flag_b for that player. A move event in the same cycle SHALL be discarded.
REQ-024 A tick coinciding with a move event (without expiry) SHALL apply the decrement to the moving player, and the switch SHALL occur on the same edge.
REQ-025 A tick coinciding with a k event SHALL still decrement.
REQ-026 run_a SHALL be 1 only in RUN_A; run_b SHALL be 1 only in RUN_B.
REQ-027 flag_a and flag_b SHALL be 0 outside FLAG; exactly one SHALL be 1 in FLAG.
REQ-028 Time registers SHALL never hold non-BCD digits or sec_tens > 5.

Reset
REQ-029 Reset SHALL set state=IDLE, run_a=run_b=0, flag_a=flag_b=0, and time_a=time_b=BCD(INIT_MIN):00.
REQ-030 Reset SHALL clear both button history registers to high (released) and saved player to A.
REQ-031 Reset asserted mid-game, including in PAUSED or FLAG, SHALL take priority over all events in that cycle.

Configuration
REQ-032 Macro CHESS_INCREMENT_EN, when defined, SHALL add INC_SEC to the moving player's time when a move event switches state from RUN_A or RUN_B.
  - The addition SHALL be applied after any same-cycle tick decrement.
  - It SHALL be BCD-correct with carry into minutes.
  - It SHALL saturate at 99:59.
REQ-033 Without CHESS_INCREMENT_EN, moves SHALL not alter time, and INC_SEC SHALL have no effect. The IDLE-start move SHALL never add increment in either build.

Verification
REQ-034 Scenario 1: reset, INIT_MIN=5; right press; 3 ticks -> state=1, time_a=0x0457, time_b=0x0500, run_a=1.
REQ-035 Scenario 2: time_a=0x0100 in RUN_A; 1 tick -> time_a=0x0059; then left press -> state=2, time_a=0x0059 (0x0102 with macro, INC_SEC=3).
REQ-036 Scenario 3: RUN_B, time_b=0x0001; tick and right press in the same cycle -> state=4, flag_b=1, run_b=0, time_b=0x0000.
REQ-037 Scenario 4: RUN_A; k press -> state=3; 5 ticks, left and right presses -> times unchanged; k press -> state=1.
REQ-038 Scenario 5: FLAG; k press -> state=0, both times 0x0500, flags 0. Then hold left for 100 clks -> exactly one transition, state=2.
REQ-039 Scenario 6: assert reset in RUN_A at time_a=0x0312 -> next edge state=0, time_a=0x0500; a same-cycle left press is ignored.
